bram_seq_ctrl: RTL
==================

Name: bram_seq_ctrl

Overview:
Sequencer that sits directly upstream of the 64x64 read-first simple dual-port BRAM. It drives port A to fill the array with a deterministic pattern, sweeps port B to read every entry back, and checks each word against the expected pattern. It streams each word out over a valid/ready handshake to the SDU/debug path for display. It is the self-test and dump engine for the BRAM in the Lab5 regfile/SDU design.

Parameters:
AW, 6, address width; DEPTH = 2**AW
DW, 64, data width of both BRAM ports

Ports:
clka  in  1  system clock; all logic on the rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle request; accepted only in IDLE
op  in  1  0 = fill then dump (check enabled); 1 = dump only (check disabled)
pat_base  in  DW  pattern base; expected word at address k = pat_base + k (mod 2**DW)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the operation completes
wea  out  1  BRAM port A write enable
addra  out  AW  BRAM port A address
dina  out  DW  BRAM port A write data
addrb  out  AW  BRAM port B read address
doutb  in  DW  BRAM port B read data; valid one cycle after addrb is sampled
out_valid  out  1  dump word available
out_ready  in  1  consumer accepts the word
out_addr  out  AW  address of the current dump word
out_data  out  DW  current dump word
err_cnt  out  AW+1  number of mismatches in the last checked dump (0..DEPTH)

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0: busy, done, wea, addra, dina, addrb, out_valid, out_addr, out_data, err_cnt. BRAM contents are not touched.
- States: IDLE, FILL, RD_ISSUE, RD_CAP, OUT, FIN.
- IDLE:
  - start=1 latches op and pat_base, clears err_cnt, and sets the address counter to 0.
  - Next state is FILL if op=0, or RD_ISSUE if op=1.
  - start is ignored in every other state.
- FILL:
  - Each cycle: wea=1, addra=cnt, dina=pat_base_q+cnt; cnt increments.
  - When cnt=DEPTH-1 is written, cnt resets to 0 and the next state is RD_ISSUE.
  - Exactly DEPTH consecutive write cycles. wea is 0 in every other state.
- RD_ISSUE: addrb=cnt for one cycle, then go to RD_CAP.
- RD_CAP:
  - doutb is valid in this cycle. Register out_data=doutb and out_addr=cnt.
  - If op_q=0 and doutb != pat_base_q+cnt, err_cnt increments.
  - Next state is OUT.
- OUT:
  - out_valid=1. out_data and out_addr are held stable until the handshake completes (out_valid & out_ready on the same edge).
  - On handshake, out_valid drops next cycle. If cnt=DEPTH-1 go to FIN; otherwise cnt+1 and go to RD_ISSUE.
  - out_ready while not in OUT has no effect.
- FIN: done=1 for exactly one cycle, then IDLE. err_cnt holds its value until the next accepted start.
- Latency:
  - Fill is DEPTH cycles.
  - Each dump word takes a minimum of 3 cycles (RD_ISSUE, RD_CAP, OUT with out_ready held high).
  - Best case, start to done for op=0 is 1 + DEPTH + 3*DEPTH cycles.
- Address counter wraps only via the explicit DEPTH-1 check; it never overflows. Pattern addition is modulo 2**DW.
- addrb holds its last value outside RD_ISSUE. addra and dina hold their last value while wea=0.
- Reset asserted mid-operation returns to IDLE immediately; any in-flight dump word is dropped and no done pulse is produced.

Test Plan:
- Reset, then start with op=0, pat_base=0, BRAM model read-first, out_ready=1 → 64 writes with dina=1..64 at addra=0..63? No: dina=0..63 at addra=0..63; then 64 dump words with out_data=k at out_addr=k; err_cnt=0; done pulse at cycle 1+64+192 after start.
- op=0, pat_base=64'hFFFF_FFFF_FFFF_FFF0 → entry 0x10 holds 0 (wraparound); all 64 words match; err_cnt=0.
- op=0, pat_base=1, BRAM model forces entries 5 and 63 to 0 on read → err_cnt=2; out_data at out_addr=5 is 0.
- op=1 after a fill with pat_base=1, out_ready toggling 1 cycle on / 3 off → no writes (wea stays 0); 64 words 1..64 delivered in order; out_data stable while stalled; err_cnt=0.
- start pulsed while busy, and rstn pulsed low during word 20 of the dump → second start ignored; after reset all outputs are 0, no done pulse; a fresh start then runs to completion.

Source files
------------

// File: rtl/bram_seq_ctrl_if.sv
// BRAM port A/B and dump-stream signals shared by the sequencer, the BRAM and the debug consumer.
// master = sequencer side, slave = BRAM/consumer side.
interface bram_seq_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 64
);
  logic          wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  modport master (
    output wea, addra, dina, addrb,
    input  doutb,
    output out_valid, out_addr, out_data,
    input  out_ready
  );

  modport slave (
    input  wea, addra, dina, addrb,
    output doutb,
    input  out_valid, out_addr, out_data,
    output out_ready
  );
endinterface

// File: rtl/bram_seq_ctrl.sv
// BRAM self-test/dump sequencer: fills with pat_base+k, reads every entry back, checks it and streams it out.
// Fill DEPTH cycles, >=3 cycles per dump word; out_valid/out_data hold until out_ready handshake.
module bram_seq_ctrl #(
  parameter int AW = 6,
  parameter int DW = 64
) (
  input  logic                  clka,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  op,
  input  logic [DW-1:0]         pat_base,
  output logic                  busy,
  output logic                  done,
  output logic [AW:0]           err_cnt,
  bram_seq_ctrl_if.master       bus
);

  typedef enum logic [2:0] {
    IDLE, FILL, RD_ISSUE, RD_CAP, OUT, FIN
  } state_t;

  localparam logic [AW-1:0] LAST = '1;

  state_t        state_q;
  logic [AW-1:0] cnt_q;
  logic          op_q;
  logic [DW-1:0] pat_q;
  logic          busy_q, done_q, wea_q, out_valid_q;
  logic [AW-1:0] addra_q, addrb_q, out_addr_q;
  logic [DW-1:0] dina_q, out_data_q;
  logic [AW:0]   err_q;

  logic [AW-1:0] cnt_d;
  logic [DW-1:0] exp_word_d;

  assign cnt_d      = cnt_q + AW'(1);
  assign exp_word_d = pat_q + DW'(cnt_q);

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      pat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      addrb_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      err_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            pat_q  <= pat_base;
            err_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (!op) begin
              state_q <= FILL;
              wea_q   <= 1'b1;
              addra_q <= '0;
              dina_q  <= pat_base;
            end else begin
              state_q <= RD_ISSUE;
              addrb_q <= '0;
            end
          end
        end
        // Port A outputs are set up one edge ahead so the write for cnt_q is on the pins in its own cycle.
        FILL: begin
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            wea_q   <= 1'b0;
            addrb_q <= '0;
            state_q <= RD_ISSUE;
          end else begin
            cnt_q   <= cnt_d;
            addra_q <= cnt_d;
            dina_q  <= pat_q + DW'(cnt_d);
          end
        end
        RD_ISSUE: state_q <= RD_CAP;
        RD_CAP: begin
          out_data_q  <= bus.doutb;
          out_addr_q  <= cnt_q;
          out_valid_q <= 1'b1;
          if (!op_q && (bus.doutb != exp_word_d))
            err_q <= err_q + (AW+1)'(1);
          state_q <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (cnt_q == LAST) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              cnt_q   <= cnt_d;
              addrb_q <= cnt_d;
              state_q <= RD_ISSUE;
            end
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err_cnt       = err_q;
  assign bus.wea       = wea_q;
  assign bus.addra     = addra_q;
  assign bus.dina      = dina_q;
  assign bus.addrb     = addrb_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;

endmodule
